// File: rtl/game_flow_controller.sv
// Frame-synchronous game sequencer: derives a per-frame tick from v_sync and runs
// the IDLE/PLAY/HIT/PAUSE/OVER flow, gating movement and tracking lives and score.
module game_flow_controller #(
    parameter int LIVES_INIT = 3,
    parameter int HIT_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        v_sync,
    input  logic        collision,
    input  logic        start_btn,
    input  logic        pause_btn,
    output logic        move_en,
    output logic        obj_hold,
    output logic [2:0]  state,
    output logic [2:0]  lives,
    output logic [15:0] score,
    output logic        blink,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        HIT   = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        vs_q;
    logic [1:0]  btn_prev_q, btn_prev_d;
    logic        coll_f_q, coll_f_d;
    logic [2:0]  lives_q, lives_d;
    logic [15:0] score_q, score_d;
    logic [7:0]  hit_cnt_q, hit_cnt_d;
    logic        move_en_q, move_en_d;
    logic        obj_hold_q, obj_hold_d;
    logic        blink_q, blink_d;
    logic        game_over_q, game_over_d;

    logic        tick;
    logic        start_press;
    logic        pause_press;
    logic        hit_now;
    logic [15:0] score_inc;

    // btn_prev[0] tracks start, btn_prev[1] tracks pause
    assign tick        = vs_q & ~v_sync;
    assign start_press = start_btn & ~btn_prev_q[0];
    assign pause_press = pause_btn & ~btn_prev_q[1];
    assign hit_now     = coll_f_q | (collision & (state_q == PLAY));
    assign score_inc   = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            vs_q        <= 1'b1;
            btn_prev_q  <= 2'b11;
            coll_f_q    <= 1'b0;
            lives_q     <= 3'd0;
            score_q     <= 16'd0;
            hit_cnt_q   <= 8'd0;
            move_en_q   <= 1'b0;
            obj_hold_q  <= 1'b1;
            blink_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vs_q        <= v_sync;
            btn_prev_q  <= btn_prev_d;
            coll_f_q    <= coll_f_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            hit_cnt_q   <= hit_cnt_d;
            move_en_q   <= move_en_d;
            obj_hold_q  <= obj_hold_d;
            blink_q     <= blink_d;
            game_over_q <= game_over_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        btn_prev_d = btn_prev_q;
        coll_f_d   = coll_f_q;
        lives_d    = lives_q;
        score_d    = score_q;
        hit_cnt_d  = hit_cnt_q;
        move_en_d  = 1'b0;

        // A collision in the tick cycle is already folded into hit_now, so clearing wins
        if (tick) begin
            coll_f_d   = 1'b0;
            btn_prev_d = {pause_btn, start_btn};
        end else if (collision && (state_q == PLAY)) begin
            coll_f_d = 1'b1;
        end

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (start_press) begin
                        state_d   = PLAY;
                        lives_d   = 3'(LIVES_INIT);
                        score_d   = 16'd0;
                        hit_cnt_d = 8'd0;
                    end
                end
                PLAY: begin
                    if (hit_now) begin
                        if (lives_q <= 3'd1) begin
                            state_d = OVER;
                            lives_d = 3'd0;
                        end else begin
                            state_d   = HIT;
                            lives_d   = lives_q - 3'd1;
                            hit_cnt_d = 8'(HIT_FRAMES);
                        end
                    end else if (pause_press) begin
                        state_d = PAUSE;
                    end else begin
                        move_en_d = 1'b1;
                        score_d   = score_inc;
                    end
                end
                HIT: begin
                    move_en_d = 1'b1;
                    score_d   = score_inc;
                    hit_cnt_d = hit_cnt_q - 8'd1;
                    if (hit_cnt_q == 8'd1) begin
                        state_d = PLAY;
                    end
                end
                PAUSE: begin
                    if (pause_press) begin
                        state_d = PLAY;
                    end
                end
                OVER: begin
                    if (start_press) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        obj_hold_d  = (state_d == IDLE);
        blink_d     = (state_d == HIT) & hit_cnt_d[2];
        game_over_d = (state_d == OVER);
    end

    assign move_en   = move_en_q;
    assign obj_hold  = obj_hold_q;
    assign state     = state_q;
    assign lives     = lives_q;
    assign score     = score_q;
    assign blink     = blink_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller: walks through start, play, hit grace,
// pause, game over, score saturation and asynchronous reset with hand-computed values.
module tb_game_flow_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        vSync;
    logic        collision;
    logic        startBtn;
    logic        pauseBtn;
    logic        moveEn;
    logic        objHold;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic [15:0] score;
    logic        blink;
    logic        gameOver;

    int passCount  = 0;
    int failCount  = 0;
    int checkCount = 0;

    game_flow_controller #(
        .LIVES_INIT(3),
        .HIT_FRAMES(60)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .v_sync    (vSync),
        .collision (collision),
        .start_btn (startBtn),
        .pause_btn (pauseBtn),
        .move_en   (moveEn),
        .obj_hold  (objHold),
        .state     (state),
        .lives     (lives),
        .score     (score),
        .blink     (blink),
        .game_over (gameOver)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic startV, input logic pauseV, input logic collV);
        startBtn  = startV;
        pauseBtn  = pauseV;
        collision = collV;
    endtask

    // Frame boundary: outputs are sampled on the negedge right after the tick edge
    task automatic doTick();
        repeat (2) @(negedge clk);
        vSync = 1'b0;
        @(negedge clk);
        vSync = 1'b1;
    endtask

    task automatic doTicks(input int n);
        for (int i = 0; i < n; i++) doTick();
    endtask

    task automatic pulseCollision();
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        vSync = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_state", 16'(state), 16'd0);
        checkOutput("rst_lives", 16'(lives), 16'd0);
        checkOutput("rst_score", score, 16'd0);
        checkOutput("rst_move_en", 16'(moveEn), 16'd0);
        checkOutput("rst_obj_hold", 16'(objHold), 16'd1);
        checkOutput("rst_blink", 16'(blink), 16'd0);
        checkOutput("rst_game_over", 16'(gameOver), 16'd0);
        reset = 1'b0;

        doTicks(3);
        checkOutput("idle_state", 16'(state), 16'd0);

        applyStimulus(1'b1, 1'b0, 1'b0);
        doTick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("start_state", 16'(state), 16'd1);
        checkOutput("start_lives", 16'(lives), 16'd3);
        checkOutput("start_score", score, 16'd0);
        checkOutput("start_obj_hold", 16'(objHold), 16'd0);
        checkOutput("start_move_en", 16'(moveEn), 16'd0);

        for (int i = 0; i < 5; i++) begin
            doTick();
            checkOutput("play_move_en", 16'(moveEn), 16'd1);
        end
        checkOutput("play_score5", score, 16'd5);
        @(negedge clk);
        checkOutput("move_en_one_clk", 16'(moveEn), 16'd0);

        pulseCollision();
        doTick();
        checkOutput("hit_state", 16'(state), 16'd2);
        checkOutput("hit_lives", 16'(lives), 16'd2);
        checkOutput("hit_score", score, 16'd5);
        checkOutput("hit_blink_k0", 16'(blink), 16'd1);
        doTick();
        checkOutput("hit_blink_k1", 16'(blink), 16'd0);
        checkOutput("hit_move_en", 16'(moveEn), 16'd1);
        doTicks(3);
        checkOutput("hit_blink_k4", 16'(blink), 16'd0);
        doTick();
        checkOutput("hit_blink_k5", 16'(blink), 16'd1);
        pulseCollision();
        doTicks(54);
        checkOutput("hit_k59_state", 16'(state), 16'd2);
        checkOutput("hit_coll_ignored", 16'(lives), 16'd2);
        doTick();
        checkOutput("hit_end_state", 16'(state), 16'd1);
        checkOutput("hit_end_blink", 16'(blink), 16'd0);
        checkOutput("hit_end_score", score, 16'd65);

        applyStimulus(1'b0, 1'b1, 1'b0);
        doTick();
        checkOutput("pause_state", 16'(state), 16'd3);
        checkOutput("pause_move_en", 16'(moveEn), 16'd0);
        doTicks(10);
        checkOutput("pause_held_state", 16'(state), 16'd3);
        checkOutput("pause_score", score, 16'd65);
        applyStimulus(1'b0, 1'b0, 1'b0);
        doTick();
        checkOutput("pause_release", 16'(state), 16'd3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        doTick();
        checkOutput("resume_state", 16'(state), 16'd1);
        checkOutput("resume_score", score, 16'd65);
        applyStimulus(1'b0, 1'b0, 1'b0);
        doTick();
        checkOutput("resume_play_score", score, 16'd66);

        pulseCollision();
        doTick();
        checkOutput("hit2_lives", 16'(lives), 16'd1);
        doTicks(60);
        checkOutput("hit2_end_state", 16'(state), 16'd1);
        checkOutput("hit2_end_score", score, 16'd126);

        applyStimulus(1'b0, 1'b1, 1'b1);
        doTick();
        checkOutput("over_state", 16'(state), 16'd4);
        checkOutput("over_lives", 16'(lives), 16'd0);
        checkOutput("over_game_over", 16'(gameOver), 16'd1);
        checkOutput("over_move_en", 16'(moveEn), 16'd0);
        checkOutput("over_score", score, 16'd126);
        applyStimulus(1'b0, 1'b0, 1'b0);
        doTick();
        checkOutput("over_hold", 16'(state), 16'd4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        doTick();
        checkOutput("over_to_idle", 16'(state), 16'd0);
        checkOutput("idle_obj_hold", 16'(objHold), 16'd1);
        checkOutput("idle_game_over", 16'(gameOver), 16'd0);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        doTicks(2);
        checkOutput("held_start_idle", 16'(state), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        doTick();
        applyStimulus(1'b1, 1'b0, 1'b0);
        doTick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("restart_state", 16'(state), 16'd1);
        checkOutput("restart_lives", 16'(lives), 16'd3);
        checkOutput("restart_score", score, 16'd0);

        @(negedge clk);
        force dut.score_q = 16'hFFFE;
        repeat (2) @(negedge clk);
        release dut.score_q;
        @(negedge clk);
        checkOutput("sat_preload", score, 16'hFFFE);
        doTick();
        checkOutput("sat_first", score, 16'hFFFF);
        doTicks(4);
        checkOutput("sat_hold", score, 16'hFFFF);

        pulseCollision();
        doTick();
        checkOutput("hit3_state", 16'(state), 16'd2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_state", 16'(state), 16'd0);
        checkOutput("async_lives", 16'(lives), 16'd0);
        checkOutput("async_score", score, 16'd0);
        checkOutput("async_obj_hold", 16'(objHold), 16'd1);
        checkOutput("async_blink", 16'(blink), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        doTicks(2);
        checkOutput("post_rst_state", 16'(state), 16'd0);
        checkOutput("post_rst_move_en", 16'(moveEn), 16'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Frame-synchronous game sequencer for the VGA sprite demo. It sits between the analog button decode, the pixel-level collision signal and the per-object move blocks. It derives one tick per video frame from the VGA vertical sync and runs the game state machine (idle, play, hit, pause, game over). It also gates object movement, counts lives and score, and drives a blink control for the hit sprite.

## Interface
Parameters:
- LIVES_INIT, 3: lives loaded on game start; legal 1..7
- HIT_FRAMES, 60: frames of post-hit grace period; legal 1..255

Ports:
- clk  in  1  pixel clock (25 MHz domain, same as VGA timing)
- reset  in  1  asynchronous, active-high reset
- v_sync  in  1  VGA vertical sync, active-low pulse, generated in the clk domain
- collision  in  1  pixel-level overlap of player and enemy draw requests
- start_btn  in  1  start button level, 1 = pressed
- pause_btn  in  1  pause button level, 1 = pressed
- move_en  out  1  one-cycle pulse per frame; move blocks advance positions only on it
- obj_hold  out  1  level; holds move blocks at their initial positions
- state  out  3  0 IDLE, 1 PLAY, 2 HIT, 3 PAUSE, 4 OVER
- lives  out  3  remaining lives
- score  out  16  frames survived, binary, saturating
- blink  out  1  1 = suppress player sprite this frame
- game_over  out  1  level, high in OVER

Clock is clk; reset is asynchronous, active-high, named reset. Top level inverts for resetN consumers.

## Operation
- Frame tick:
  - v_sync is registered once into vs_q.
  - tick = vs_q & ~v_sync. This is one cycle, on the first clk where the falling edge is seen.
- Button sampling happens only on tick (frame-rate debounce):
  - btn_prev[1:0] holds the previous-tick samples.
  - A press is a button that is high now and whose btn_prev bit is 0.
  - Presses are evaluated only in the tick cycle.
- Collision flag coll_f:
  - Set on any clk where collision=1 and state=PLAY.
  - Cleared on every tick.
  - At a tick the effective hit is coll_f | (collision & state==PLAY).
  - Collisions in any other state are ignored.
- FSM, which transitions only on tick:
  - IDLE: on start press → PLAY; lives=LIVES_INIT, score=0.
  - PLAY, priority hit > pause > normal:
    - hit with lives==1 → OVER, lives=0.
    - hit with lives>1 → HIT, lives−1, hit_cnt=HIT_FRAMES.
    - pause press → PAUSE.
    - otherwise stay, pulse move_en, score+1 saturating at 16'hFFFF.
  - HIT:
    - Pulse move_en and score+1 every tick.
    - hit_cnt−1 each tick; when hit_cnt==1 at a tick → PLAY.
    - pause and start are ignored.
  - PAUSE: on pause press → PLAY. No move_en, score frozen.
  - OVER: on start press → IDLE. lives and score are held for display.
- Outputs:
  - obj_hold = 1 in IDLE.
  - blink = hit_cnt[2] in HIT, else 0.
  - game_over = (state==OVER).
  - All outputs are registered.

## Timing
- Reset values: state=IDLE, lives=0, score=0, move_en=0, obj_hold=1, blink=0, game_over=0, hit_cnt=0, coll_f=0, btn_prev=2'b11, vs_q=1.
  - btn_prev=2'b11 means a button held through reset does not register as a press.
- Latency:
  - Falling edge of v_sync to tick: 1 clk.
  - Tick to updated state, lives, score and move_en: 1 clk.
  - move_en is high for exactly one clk per qualifying frame.
- A reset mid-game returns everything to reset values immediately (asynchronous assert). Operation resumes on the first tick after release.
- start and pause pressed on the same tick:
  - Each state uses only its own button; the other is ignored.
  - btn_prev updates for both.
- A collision in the same clk as the tick counts toward that tick's evaluation, then coll_f clears.
- Widths:
  - lives is 3 bits and never decrements below 0.
  - hit_cnt is 8 bits.
  - score saturates and does not wrap.

## Test plan
- Reset, then 3 frames idle, then start held for 1 frame → state=1, lives=3, score=0. move_en pulses once per following frame, and score=5 after 5 frames.
- In PLAY with lives=3, a 1-clk collision pulse mid-frame → at the next tick state=2, lives=2, blink toggles every 4 frames. After HIT_FRAMES=60 ticks state=1. A collision during HIT leaves lives=2.
- lives=1, collision and pause both asserted at the same tick → state=4, lives=0, game_over=1, no move_en. A following start press → state=0, obj_hold=1.
- PLAY, pause press → state=3 and score frozen across 10 frames. pause held continuously → no resume. Release then press → state=1.
- start held high through reset release → stays IDLE until released and pressed again. Score forced near 16'hFFFE and run 5 frames → score=16'hFFFF.
- Reset asserted mid-HIT, asynchronously between ticks → outputs at reset values in the same cycle. No move_en until a new start.
